// File: rtl/combo_lock_pkg.sv
// Shared types and defaults for the combo lock sequence checker.
package combo_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY,
    OPEN,
    FAIL,
    LOCKOUT
  } lock_state_e;

  localparam int unsigned DEF_DIGIT_W  = 4;
  localparam int unsigned DEF_CODE_LEN = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/combo_cycle_timer.sv
// Loadable down-counter; done is high in the last counted cycle (count == 1).
module combo_cycle_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == WIDTH'(1));

endmodule

// File: rtl/combo_lock_check.sv
// Combo lock sequence checker: digit entry, code compare, timed unlock, failure counting.
// Define COMBO_LOCKOUT_EN to enable the lockout state after MAX_FAILS consecutive failures.
module combo_lock_check
  import combo_lock_pkg::*;
#(
  parameter int unsigned                 DIGIT_W        = DEF_DIGIT_W,
  parameter int unsigned                 CODE_LEN       = DEF_CODE_LEN,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE           = 16'h1234,
  parameter int unsigned                 UNLOCK_CYCLES  = 500,
  parameter int unsigned                 MAX_FAILS      = 3,
  parameter int unsigned                 LOCKOUT_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             enter,
  input  logic                             clear,
  output logic [$clog2(CODE_LEN)-1:0]      digit_idx,
  output logic                             unlocked,
  output logic                             error,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt,
  output logic                             locked_out
);

  localparam int unsigned IDX_W = $clog2(CODE_LEN);
  localparam int unsigned FC_W  = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMR_W = $clog2(max_u(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);

  lock_state_e        state_q, state_d;
  logic [IDX_W-1:0]   digit_idx_q, digit_idx_d;
  logic               mismatch_q, mismatch_d;
  logic               unlocked_q, unlocked_d;
  logic               error_q, error_d;
  logic [FC_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic [DIGIT_W-1:0] exp_digit;
  logic               mism_hit;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_done;

  always_comb begin
    exp_digit = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        exp_digit = CODE[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign mism_hit = mismatch_q | (digit != exp_digit);

  combo_cycle_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

`ifdef COMBO_LOCKOUT_EN
  logic locked_out_q, locked_out_d;
`endif

  always_comb begin
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    mismatch_d  = mismatch_q;
    unlocked_d  = unlocked_q;
    error_d     = 1'b0;
    fail_cnt_d  = fail_cnt_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
`ifdef COMBO_LOCKOUT_EN
    locked_out_d = locked_out_q;
`endif
    case (state_q)
      ENTRY: begin
        if (clear) begin
          digit_idx_d = '0;
          mismatch_d  = 1'b0;
        end else if (enter) begin
          if (digit_idx_q != IDX_W'(CODE_LEN - 1)) begin
            digit_idx_d = digit_idx_q + IDX_W'(1);
            mismatch_d  = mism_hit;
          end else begin
            // Index/mismatch clear here so FAIL and OPEN both start a fresh attempt.
            digit_idx_d = '0;
            mismatch_d  = 1'b0;
            if (!mism_hit) begin
              state_d    = OPEN;
              unlocked_d = 1'b1;
              fail_cnt_d = '0;
              tmr_load   = 1'b1;
              tmr_val    = TMR_W'(UNLOCK_CYCLES);
            end else begin
              state_d    = FAIL;
              error_d    = 1'b1;
              fail_cnt_d = (fail_cnt_q == FC_W'(MAX_FAILS)) ? fail_cnt_q
                                                             : fail_cnt_q + FC_W'(1);
            end
          end
        end
      end
      FAIL: begin
        state_d = ENTRY;
`ifdef COMBO_LOCKOUT_EN
        if (fail_cnt_q == FC_W'(MAX_FAILS)) begin
          state_d      = LOCKOUT;
          locked_out_d = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = TMR_W'(LOCKOUT_CYCLES);
        end
`endif
      end
      OPEN: begin
        if (enter) begin
          state_d    = ENTRY;
          unlocked_d = 1'b0;
          tmr_load   = 1'b1;
        end else if (tmr_done) begin
          state_d    = ENTRY;
          unlocked_d = 1'b0;
        end
      end
`ifdef COMBO_LOCKOUT_EN
      LOCKOUT: begin
        if (tmr_done) begin
          state_d      = ENTRY;
          locked_out_d = 1'b0;
          fail_cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = ENTRY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ENTRY;
      digit_idx_q <= '0;
      mismatch_q  <= 1'b0;
      unlocked_q  <= 1'b0;
      error_q     <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      digit_idx_q <= digit_idx_d;
      mismatch_q  <= mismatch_d;
      unlocked_q  <= unlocked_d;
      error_q     <= error_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

`ifdef COMBO_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked_out_q <= 1'b0;
    end else begin
      locked_out_q <= locked_out_d;
    end
  end

  assign locked_out = locked_out_q;
`else
  assign locked_out = 1'b0;
`endif

  assign digit_idx = digit_idx_q;
  assign unlocked  = unlocked_q;
  assign error     = error_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_combo_lock_check.sv
// Self-checking bench for combo_lock_check: vector table, directed corner cases, random traffic vs model.
module tb_combo_lock_check;

  localparam int unsigned UNL  = 4;
  localparam int unsigned LCK  = 8;
  localparam int unsigned MAXF = 3;
  localparam int unsigned CLEN = 4;
  localparam logic [15:0] TB_CODE = 16'h1234;
`ifdef COMBO_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit;
  logic       enter;
  logic       clear;
  logic [1:0] digit_idx;
  logic       unlocked;
  logic       error;
  logic [1:0] fail_cnt;
  logic       locked_out;

  always #5 clk = ~clk;

  combo_lock_check #(
    .DIGIT_W        (4),
    .CODE_LEN       (4),
    .CODE           (16'h1234),
    .UNLOCK_CYCLES  (UNL),
    .MAX_FAILS      (MAXF),
    .LOCKOUT_CYCLES (LCK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit      (digit),
    .enter      (enter),
    .clear      (clear),
    .digit_idx  (digit_idx),
    .unlocked   (unlocked),
    .error      (error),
    .fail_cnt   (fail_cnt),
    .locked_out (locked_out)
  );

  int n_checks   = 0;
  int n_errors   = 0;
  int err_pulses = 0;

  // Reference model: digits typed so far plus remaining unlock/lockout time.
  int code_dig[CLEN];
  int m_digits[$];
  int m_unlock_left;
  int m_lock_left;
  int m_fails;
  bit m_error;

  typedef struct {
    logic       en;
    logic       cl;
    logic [3:0] dg;
    logic       exp_unl;
    logic       exp_err;
    logic [1:0] exp_fc;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digits.delete();
    m_unlock_left = 0;
    m_lock_left   = 0;
    m_fails       = 0;
    m_error       = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic cl, input logic [3:0] dg);
    bit ok;
    if (m_error) begin
      m_error = 1'b0;
      if (LOCK_EN && m_fails == int'(MAXF)) m_lock_left = LCK;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_unlock_left > 0) begin
      if (en) m_unlock_left = 0;
      else    m_unlock_left--;
    end else if (cl) begin
      m_digits.delete();
    end else if (en) begin
      m_digits.push_back(int'(dg));
      if (m_digits.size() == int'(CLEN)) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < CLEN; i++)
          if (m_digits[i] != code_dig[i]) ok = 1'b0;
        m_digits.delete();
        if (ok) begin
          m_unlock_left = UNL;
          m_fails       = 0;
        end else begin
          m_error = 1'b1;
          if (m_fails < int'(MAXF)) m_fails++;
        end
      end
    end
  endtask

  task automatic compare_model();
    check("unlocked",   unlocked,   (m_unlock_left > 0));
    check("error",      error,      m_error);
    check("fail_cnt",   fail_cnt,   m_fails);
    check("digit_idx",  digit_idx,  m_digits.size());
    check("locked_out", locked_out, (m_lock_left > 0));
  endtask

  task automatic cycle(input logic en, input logic cl, input logic [3:0] dg);
    enter = en;
    clear = cl;
    digit = dg;
    @(posedge clk);
    model_step(en, cl, dg);
    #1;
    compare_model();
    if (error === 1'b1) err_pulses++;
    enter = 1'b0;
    clear = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int unsigned i = 0; i < CLEN; i++) cycle(1'b1, 1'b0, c[(3-i)*4 +: 4]);
    cycle(1'b0, 1'b0, 4'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_unlocked"},   unlocked,   0);
    check({tag, "_error"},      error,      0);
    check({tag, "_fail_cnt"},   fail_cnt,   0);
    check({tag, "_digit_idx"},  digit_idx,  0);
    check({tag, "_locked_out"}, locked_out, 0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lock_cycles;
    bit saw_unlock;
    logic en, cl;
    logic [3:0] dg;

    for (int unsigned i = 0; i < CLEN; i++) code_dig[i] = int'((TB_CODE >> ((CLEN-1-i)*4)) & 16'hF);

    // {en, cl, digit, unlocked, error, fail_cnt, digit_idx} after the edge
    vecs[0]  = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 2'd0, 2'd1};
    vecs[1]  = '{1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 2'd0, 2'd2};
    vecs[2]  = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 2'd0, 2'd3};
    vecs[3]  = '{1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[6]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[7]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0};
    vecs[8]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0};
    vecs[9]  = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 2'd0, 2'd1};
    vecs[10] = '{1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 2'd0, 2'd2};
    vecs[11] = '{1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 2'd0, 2'd3};
    vecs[12] = '{1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 2'd1, 2'd0};
    vecs[13] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd1, 2'd0};
    vecs[14] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 2'd1, 2'd1};
    vecs[15] = '{1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 2'd1, 2'd2};
    vecs[16] = '{1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd1, 2'd0};
    vecs[17] = '{1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 2'd1, 2'd0};
    vecs[18] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 2'd1, 2'd1};
    vecs[19] = '{1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 2'd1, 2'd2};
    vecs[20] = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 2'd1, 2'd3};
    vecs[21] = '{1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 2'd0, 2'd0};
    vecs[22] = '{1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 2'd0, 2'd0};
    vecs[23] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0};

    rst   = 1'b0;
    enter = 1'b0;
    clear = 1'b0;
    digit = 4'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    for (int unsigned r = 0; r < 24; r++) begin
      cycle(vecs[r].en, vecs[r].cl, vecs[r].dg);
      check($sformatf("tbl%0d_unlocked", r),  unlocked,  vecs[r].exp_unl);
      check($sformatf("tbl%0d_error", r),     error,     vecs[r].exp_err);
      check($sformatf("tbl%0d_fail_cnt", r),  fail_cnt,  vecs[r].exp_fc);
      check($sformatf("tbl%0d_digit_idx", r), digit_idx, vecs[r].exp_idx);
    end

    // Async reset mid-OPEN, then mid-entry.
    enter_code(16'h1234);
    check("pre_rst_open", unlocked, 1);
    async_reset("rst_open");
    cycle(1'b1, 1'b0, 4'd1);
    cycle(1'b1, 1'b0, 4'd2);
    check("pre_rst_idx", digit_idx, 2);
    async_reset("rst_entry");
    enter_code(16'h1234);
    check("post_rst_unlock", unlocked, 1);
    repeat (4) cycle(1'b0, 1'b0, 4'd0);

    err_pulses = 0;
`ifdef COMBO_LOCKOUT_EN
    repeat (3) enter_code(16'h1294);
    check("lock_err_pulses", err_pulses, 3);
    check("lock_fail_cnt", fail_cnt, 3);
    lock_cycles = 0;
    saw_unlock  = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      if (locked_out !== 1'b1) break;
      lock_cycles++;
      if (unlocked === 1'b1) saw_unlock = 1'b1;
      cycle(i < 4, 1'b0, (i < 4) ? 4'(code_dig[i]) : 4'd0);
    end
    if (unlocked === 1'b1) saw_unlock = 1'b1;
    check("lock_len", lock_cycles, LCK);
    check("lock_no_unlock", saw_unlock, 0);
    check("lock_fail_cnt_after", fail_cnt, 0);
    enter_code(16'h1234);
    check("post_lock_unlock", unlocked, 1);
`else
    repeat (5) enter_code(16'h1294);
    check("nolock_err_pulses", err_pulses, 5);
    check("nolock_fail_cnt", fail_cnt, 3);
    check("nolock_locked_out", locked_out, 0);
    enter_code(16'h1234);
    check("nolock_unlock", unlocked, 1);
    check("nolock_fail_clr", fail_cnt, 0);
`endif
    repeat (4) cycle(1'b0, 1'b0, 4'd0);

    for (int unsigned k = 0; k < 600; k++) begin
      en = ($urandom_range(99) < 55);
      cl = ($urandom_range(19) == 0);
      if ($urandom_range(3) != 0 && m_digits.size() < int'(CLEN))
        dg = 4'(code_dig[m_digits.size()]);
      else
        dg = 4'($urandom_range(15));
      cycle(en, cl, dg);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
